// File: rtl/kfpga_config_loader.sv
// Purpose : byte-wide bitstream loader for the kFPGA configuration chain; checks header and XOR checksum, serialises payload LSB first.
// Latency : CLEAR_CYCLES of chain reset after start, then 1 accept cycle + up to 8 shift cycles per payload byte.
// Backpr. : data_ready only in HEADER/LOAD/CHECK; low while shifting; data_valid stalls are waited out with no timeout.
//
// Ports:
//   clock       in   configuration clock (also clocks the chain)
//   nreset      in   asynchronous active-low reset
//   start       in   single-cycle load request (honoured in IDLE, DONE, ERROR)
//   data_in     in   [7:0] bitstream byte
//   data_valid  in   data_in is valid
//   data_ready  out  loader accepts a byte this cycle
//   cfg_data    out  serial bit to the chain's config_in
//   cfg_enable  out  chain shift enable
//   cfg_nreset  out  chain reset, active low
//   busy        out  load in progress
//   done        out  last load completed with a good checksum (sticky until start)
//   error       out  last load failed (sticky until start)
module kfpga_config_loader #(
  parameter int          CONFIG_WIDTH = 2034,
  parameter int          CLEAR_CYCLES = 2,
  parameter logic [7:0]  MAGIC        = 8'hA5
) (
  input  logic       clock,
  input  logic       nreset,
  input  logic       start,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       cfg_data,
  output logic       cfg_enable,
  output logic       cfg_nreset,
  output logic       busy,
  output logic       done,
  output logic       error
);

  // Global bit counter must be able to hold CONFIG_WIDTH itself.
  localparam int BCW = $clog2(CONFIG_WIDTH + 1);
  localparam int CCW = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

  localparam logic [BCW-1:0] LP_LAST_BIT  = BCW'(CONFIG_WIDTH - 1);
  localparam logic [CCW-1:0] LP_CLR_LAST  = CCW'(CLEAR_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_HEADER,
    S_LOAD,
    S_SHIFT,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [CCW-1:0]   r_clr_cnt;
  logic [CCW-1:0]   w_clr_cnt_nxt;
  logic [BCW-1:0]   r_bit_cnt;
  logic [BCW-1:0]   w_bit_cnt_nxt;
  logic [2:0]       r_sub_cnt;
  logic [2:0]       w_sub_cnt_nxt;
  // Bit 0 of the latched byte goes straight to cfg_data, so only the
  // remaining seven bits need to be held here.
  logic [6:0]       r_shift;
  logic [6:0]       w_shift_nxt;
  logic [7:0]       r_csum;
  logic [7:0]       w_csum_nxt;

  logic             r_data_ready;
  logic             r_cfg_data;
  logic             r_cfg_enable;
  logic             r_cfg_nreset;
  logic             r_busy;
  logic             r_done;
  logic             r_error;

  logic             w_data_ready_nxt;
  logic             w_cfg_data_nxt;
  logic             w_cfg_enable_nxt;
  logic             w_cfg_nreset_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_error_nxt;

  logic             w_accept;
  logic             w_last_bit;
  logic             w_byte_end;

  assign w_accept   = data_valid && r_data_ready;
  assign w_last_bit = (r_bit_cnt == LP_LAST_BIT);
  // A byte ends after 8 shifts, or early on the chain's final bit, which
  // drops the unused high bits of the last payload byte.
  assign w_byte_end = (r_sub_cnt == 3'd7) || w_last_bit;

  // --------------------------------------------------------------------
  // State register and datapath registers
  // --------------------------------------------------------------------
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      r_state      <= S_IDLE;
      r_clr_cnt    <= '0;
      r_bit_cnt    <= '0;
      r_sub_cnt    <= '0;
      r_shift      <= '0;
      r_csum       <= '0;
      r_data_ready <= 1'b0;
      r_cfg_data   <= 1'b0;
      r_cfg_enable <= 1'b0;
      r_cfg_nreset <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_clr_cnt    <= w_clr_cnt_nxt;
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_sub_cnt    <= w_sub_cnt_nxt;
      r_shift      <= w_shift_nxt;
      r_csum       <= w_csum_nxt;
      r_data_ready <= w_data_ready_nxt;
      r_cfg_data   <= w_cfg_data_nxt;
      r_cfg_enable <= w_cfg_enable_nxt;
      r_cfg_nreset <= w_cfg_nreset_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_error      <= w_error_nxt;
    end
  end

  // --------------------------------------------------------------------
  // Next-state and next-output logic
  // --------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_clr_cnt_nxt  = r_clr_cnt;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_sub_cnt_nxt  = r_sub_cnt;
    w_shift_nxt    = r_shift;
    w_csum_nxt     = r_csum;
    w_cfg_data_nxt   = 1'b0;
    w_cfg_enable_nxt = 1'b0;

    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          w_state_nxt   = S_CLEAR;
          w_clr_cnt_nxt = '0;
          w_bit_cnt_nxt = '0;
          w_sub_cnt_nxt = '0;
          w_csum_nxt    = '0;
        end
      end

      S_CLEAR: begin
        if (r_clr_cnt == LP_CLR_LAST) begin
          w_state_nxt = S_HEADER;
        end else begin
          w_clr_cnt_nxt = r_clr_cnt + 1'b1;
        end
      end

      S_HEADER: begin
        if (w_accept) begin
          w_state_nxt = (data_in == MAGIC) ? S_LOAD : S_ERROR;
        end
      end

      S_LOAD: begin
        // The final shift cycle hands straight to CHECK, so every byte
        // accepted here is payload.
        if (w_accept) begin
          w_state_nxt      = S_SHIFT;
          w_shift_nxt      = data_in[7:1];
          w_csum_nxt       = r_csum ^ data_in;
          w_sub_cnt_nxt    = '0;
          w_cfg_data_nxt   = data_in[0];
          w_cfg_enable_nxt = 1'b1;
        end
      end

      S_SHIFT: begin
        // Each cycle here is one enable-high cycle seen by the chain.
        w_bit_cnt_nxt = r_bit_cnt + 1'b1;
        if (w_byte_end) begin
          w_state_nxt = w_last_bit ? S_CHECK : S_LOAD;
        end else begin
          w_sub_cnt_nxt    = r_sub_cnt + 3'd1;
          w_cfg_data_nxt   = r_shift[0];
          w_shift_nxt      = {1'b0, r_shift[6:1]};
          w_cfg_enable_nxt = 1'b1;
        end
      end

      S_CHECK: begin
        if (w_accept) begin
          w_state_nxt = (data_in == r_csum) ? S_DONE : S_ERROR;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Status outputs are registered copies of the state being entered so
    // they line up cycle-for-cycle with r_state.
    w_data_ready_nxt = (w_state_nxt == S_HEADER) ||
                       (w_state_nxt == S_LOAD)   ||
                       (w_state_nxt == S_CHECK);
    w_busy_nxt       = (w_state_nxt == S_CLEAR)  ||
                       (w_state_nxt == S_HEADER) ||
                       (w_state_nxt == S_LOAD)   ||
                       (w_state_nxt == S_SHIFT)  ||
                       (w_state_nxt == S_CHECK);
    w_done_nxt       = (w_state_nxt == S_DONE);
    w_error_nxt      = (w_state_nxt == S_ERROR);
    // Chain held cleared while clearing and after a failed load, so the
    // fabric never runs a partial or corrupt image.
    w_cfg_nreset_nxt = !((w_state_nxt == S_CLEAR) || (w_state_nxt == S_ERROR));
  end

  assign data_ready = r_data_ready;
  assign cfg_data   = r_cfg_data;
  assign cfg_enable = r_cfg_enable;
  assign cfg_nreset = r_cfg_nreset;
  assign busy       = r_busy;
  assign done       = r_done;
  assign error      = r_error;

endmodule

// File: tb/tb_kfpga_config_loader.sv
// Purpose : directed + randomised bench for kfpga_config_loader (10-bit and default-width instances).
// Latency : n/a (bench).
// Backpr. : drives data_valid with optional random stalls; waits on data_ready.
module tb_kfpga_config_loader;

  localparam int W_SMALL = 10;
  localparam int W_DFLT  = 2034;
  localparam int NB_DFLT = (W_DFLT + 7) / 8;

  logic       clock = 1'b0;
  logic       nreset = 1'b1;
  logic       start = 1'b0;
  logic       sel = 1'b0;           // 0: small instance, 1: default instance
  logic [7:0] data_in = 8'h00;
  logic       data_valid = 1'b0;

  logic start_s, start_d;
  logic s_ready, s_data, s_en, s_nrst, s_busy, s_done, s_err;
  logic d_ready, d_data, d_en, d_nrst, d_busy, d_done, d_err;
  logic cur_ready, cur_data, cur_en, cur_nrst, cur_busy, cur_done, cur_err;

  assign start_s = start && !sel;
  assign start_d = start && sel;

  always #5 clock = ~clock;

  kfpga_config_loader #(.CONFIG_WIDTH(W_SMALL)) u_small (
    .clock(clock), .nreset(nreset), .start(start_s), .data_in(data_in),
    .data_valid(data_valid), .data_ready(s_ready), .cfg_data(s_data),
    .cfg_enable(s_en), .cfg_nreset(s_nrst), .busy(s_busy), .done(s_done), .error(s_err)
  );

  kfpga_config_loader u_dflt (
    .clock(clock), .nreset(nreset), .start(start_d), .data_in(data_in),
    .data_valid(data_valid), .data_ready(d_ready), .cfg_data(d_data),
    .cfg_enable(d_en), .cfg_nreset(d_nrst), .busy(d_busy), .done(d_done), .error(d_err)
  );

  assign cur_ready = sel ? d_ready : s_ready;
  assign cur_data  = sel ? d_data  : s_data;
  assign cur_en    = sel ? d_en    : s_en;
  assign cur_nrst  = sel ? d_nrst  : s_nrst;
  assign cur_busy  = sel ? d_busy  : s_busy;
  assign cur_done  = sel ? d_done  : s_done;
  assign cur_err   = sel ? d_err   : s_err;

  int   checks = 0;
  int   errors = 0;
  int   tmo_cnt = 0;
  int   en_cnt = 0;
  int   viol_cnt = 0;
  logic obs_q[$];
  logic [7:0] pay[$];

  // Chain-side monitor: every enable-high cycle pushes cfg_data into the
  // chain. Shift enable is only legal while busy and not taking bytes.
  always @(negedge clock) begin
    if (cur_en === 1'b1) begin
      obs_q.push_back(cur_data);
      en_cnt = en_cnt + 1;
      if (cur_busy !== 1'b1 || cur_ready !== 1'b0) viol_cnt = viol_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xor_all();
    logic [7:0] x = 8'h00;
    foreach (pay[i]) x = x ^ pay[i];
    return x;
  endfunction

  // Chain model: stream bit k is payload byte k/8, bit k%8 (LSB first);
  // the bit shifted at step k ends at chain position w-1-k.
  function automatic int chain_mismatches(input int w);
    int bad = 0;
    if (obs_q.size() != w) return -1;
    for (int p = 0; p < w; p++) begin
      int k = w - 1 - p;
      logic [7:0] b = pay[k / 8];
      logic exp_bit = b[k % 8];
      logic got_bit = obs_q[w - 1 - p];
      if (got_bit !== exp_bit) bad++;
    end
    return bad;
  endfunction

  task automatic reset_obs();
    obs_q.delete();
    en_cnt = 0;
    viol_cnt = 0;
    tmo_cnt = 0;
  endtask

  task automatic pulse_start(output int low_cycles);
    bit got = 0;
    low_cycles = 0;
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (cur_ready === 1'b1) begin got = 1; break; end
      if (cur_nrst === 1'b0) low_cycles++;
      @(negedge clock);
    end
    if (!got) tmo_cnt++;
  endtask

  task automatic send_byte(input logic [7:0] b, input int stall_pct);
    bit sent = 0;
    for (int g = 0; g < 2000 && !sent; g++) begin
      @(negedge clock);
      if (int'($urandom_range(99)) < stall_pct) begin
        data_valid = 1'b0;
      end else begin
        data_valid = 1'b1;
        data_in    = b;
        if (cur_ready === 1'b1) sent = 1;
      end
    end
    if (sent) begin
      @(posedge clock);
      #1 data_valid = 1'b0;
    end else begin
      data_valid = 1'b0;
      tmo_cnt++;
    end
  endtask

  task automatic wait_end();
    bit fin = 0;
    for (int i = 0; i < 200 && !fin; i++) begin
      @(negedge clock);
      if (cur_done === 1'b1 || cur_err === 1'b1) fin = 1;
    end
    if (!fin) tmo_cnt++;
  endtask

  task automatic fill_random(input int n);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(8'($urandom_range(255)));
  endtask

  initial begin
    int lowc;
    int acc;

    // ---- reset values and idle ----
    #3 nreset = 1'b0;
    #1;
    check("rst_small_outs", {s_ready, s_data, s_en, s_nrst, s_busy, s_done, s_err}, 7'b0);
    check("rst_dflt_outs",  {d_ready, d_data, d_en, d_nrst, d_busy, d_done, d_err}, 7'b0);
    repeat (3) @(negedge clock);
    nreset = 1'b1;
    sel = 1'b1;
    reset_obs();
    @(negedge clock);
    check("idle_nreset", cur_nrst, 1);
    check("idle_ready_done_err", {cur_ready, cur_done, cur_err}, 3'b000);
    repeat (100) @(negedge clock);
    check("idle_no_enable", en_cnt, 0);

    // ---- 10-bit chain, good checksum ----
    sel = 1'b0;
    reset_obs();
    pay.delete(); pay.push_back(8'h5A); pay.push_back(8'h03);
    pulse_start(lowc);
    check("w10_clear_len", lowc, 2);
    check("w10_busy", cur_busy, 1);
    send_byte(8'hA5, 0);
    foreach (pay[i]) send_byte(pay[i], 0);
    check("w10_model_csum", xor_all(), 8'h59);
    send_byte(8'h59, 0);
    wait_end();
    check("w10_en_cycles", en_cnt, W_SMALL);
    check("w10_chain", chain_mismatches(W_SMALL), 0);
    check("w10_done_err", {cur_done, cur_err, cur_busy, cur_nrst}, 4'b1001);
    check("w10_timeouts", tmo_cnt, 0);
    check("w10_en_legal", viol_cnt, 0);

    // ---- 10-bit chain, bad checksum ----
    reset_obs();
    pulse_start(lowc);
    check("w10b_clear_len", lowc, 2);
    send_byte(8'hA5, 20);
    foreach (pay[i]) send_byte(pay[i], 20);
    send_byte(8'h00, 20);
    wait_end();
    check("w10b_en_cycles", en_cnt, W_SMALL);
    check("w10b_err_state", {cur_done, cur_err, cur_nrst, cur_busy}, 4'b0100);
    check("w10b_timeouts", tmo_cnt, 0);

    // ---- bad header ----
    reset_obs();
    pulse_start(lowc);
    send_byte(8'h3C, 0);
    wait_end();
    check("hdr_err", {cur_done, cur_err}, 2'b01);
    data_valid = 1'b1; data_in = 8'hA5;
    acc = 0;
    repeat (20) begin
      @(negedge clock);
      if (cur_ready === 1'b1) acc++;
    end
    data_valid = 1'b0;
    check("hdr_no_accept", acc, 0);
    check("hdr_no_enable", en_cnt, 0);
    check("hdr_timeouts", tmo_cnt, 0);

    // ---- default width, random payload, 30% valid stalls ----
    sel = 1'b1;
    reset_obs();
    fill_random(NB_DFLT);
    pulse_start(lowc);
    check("dflt_clear_len", lowc, 2);
    send_byte(8'hA5, 30);
    foreach (pay[i]) send_byte(pay[i], 30);
    send_byte(xor_all(), 30);
    wait_end();
    check("dflt_en_cycles", en_cnt, W_DFLT);
    check("dflt_chain", chain_mismatches(W_DFLT), 0);
    check("dflt_done_err", {cur_done, cur_err}, 2'b10);
    check("dflt_timeouts", tmo_cnt, 0);
    check("dflt_en_legal", viol_cnt, 0);

    // ---- reset in the 100th shift cycle, then a clean reload ----
    reset_obs();
    fill_random(NB_DFLT);
    pulse_start(lowc);
    send_byte(8'hA5, 0);
    for (int i = 0; i < 13; i++) send_byte(pay[i], 0);
    acc = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      #1;
      if (en_cnt >= 100) begin acc = 1; break; end
    end
    check("mid_reached_100", acc, 1);
    check("mid_en_count", en_cnt, 100);
    nreset = 1'b0;
    #1;
    check("mid_rst_outs", {d_ready, d_data, d_en, d_nrst, d_busy, d_done, d_err}, 7'b0);
    repeat (2) @(negedge clock);
    nreset = 1'b1;
    @(negedge clock);
    check("mid_post_idle", {cur_nrst, cur_busy, cur_done, cur_err}, 4'b1000);
    reset_obs();
    fill_random(NB_DFLT);
    pulse_start(lowc);
    check("re_clear_len", lowc, 2);
    send_byte(8'hA5, 10);
    foreach (pay[i]) send_byte(pay[i], 10);
    send_byte(xor_all(), 10);
    wait_end();
    check("re_en_cycles", en_cnt, W_DFLT);
    check("re_chain", chain_mismatches(W_DFLT), 0);
    check("re_done_err", {cur_done, cur_err, cur_nrst}, 3'b101);
    check("re_timeouts", tmo_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute backstop so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/kfpga_config_loader.md
Name: kfpga_config_loader

Overview:
- Upstream feeder of the kFPGA configuration shift register: accepts a byte-wide bitstream over a valid/ready handshake, validates header and checksum, and serialises payload bits into the chain.
- Drives the chain's serial data, enable and chain reset; sits between the host/SPI front end and the core top level.
- Runs entirely in the configuration clock domain.

Parameters:
- CONFIG_WIDTH, 2034, number of bits in the configuration chain.
- CLEAR_CYCLES, 2, cycles cfg_nreset is held low before loading (minimum 1).
- MAGIC, 8'hA5, required header byte.

Ports:
- clock  input  1  configuration clock (drives the chain's config_clock).
- nreset  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin a load; ignored unless in IDLE, DONE or ERROR.
- data_in  input  8  bitstream byte.
- data_valid  input  1  data_in is valid.
- data_ready  output  1  loader accepts a byte this cycle.
- cfg_data  output  1  serial bit to the chain's config_in.
- cfg_enable  output  1  chain shift enable.
- cfg_nreset  output  1  chain reset, active low.
- busy  output  1  load in progress.
- done  output  1  last load completed with a good checksum; held until the next start.
- error  output  1  last load failed; held until the next start.

Behaviour:
- One clock; reset is asynchronous and active-low on nreset.
- All outputs are registered.
- Reset values: data_ready=0, cfg_data=0, cfg_enable=0, cfg_nreset=0, busy=0, done=0, error=0.
- One cycle after reset release, cfg_nreset=1 in IDLE.
- Reset mid-load aborts immediately: the chain is cleared via cfg_nreset=0.
- NBYTES = ceil(CONFIG_WIDTH/8); the default gives 255 bytes.
- A byte is accepted on a clock edge where data_valid && data_ready.
- States:
  - IDLE: waits for start.
  - CLEAR: cfg_nreset=0 for exactly CLEAR_CYCLES cycles; busy=1; done and error cleared on entry.
  - HEADER: data_ready=1. An accepted byte equal to MAGIC goes to LOAD; any other value goes to ERROR.
  - LOAD: data_ready=1. An accepted byte is latched into the shift byte, XORed into the checksum, and the state goes to SHIFT. If all payload bits are already sent, the state goes to CHECK instead.
  - SHIFT: data_ready=0, cfg_enable=1. cfg_data carries one bit per cycle, LSB first, from the latched byte. SHIFT lasts 8 cycles, except the final byte, which lasts CONFIG_WIDTH mod 8 cycles (8 if the remainder is 0); its unused high bits are dropped. Afterwards the state returns to LOAD.
  - CHECK: data_ready=1. The accepted byte is compared with the running XOR. Equal goes to DONE; unequal goes to ERROR.
  - DONE: done=1, busy=0, cfg_nreset=1. The chain contents are retained.
  - ERROR: error=1, busy=0, cfg_nreset=0 (chain held cleared so the fabric never runs a bad image).
- Bit ordering: the first payload bit shifted ends at chain position CONFIG_WIDTH-1; the last bit ends at position 0.
- A global bit counter (width clog2(CONFIG_WIDTH+1)) counts cfg_enable cycles.
  - Exactly CONFIG_WIDTH enable-high cycles occur per successful load.
  - cfg_enable is never high outside SHIFT.
- data_valid stalls are tolerated in HEADER, LOAD and CHECK with no timeout. Data is never accepted in other states.
- Back-to-back bytes: each payload byte costs 1 accept cycle plus its shift cycles (9 cycles for a full byte).
- start while busy is ignored. start in DONE or ERROR restarts from CLEAR.
- Checksum is the XOR of all NBYTES payload bytes as received, including dropped high bits.

Test Plan:
- Reset then idle -> after release cfg_nreset=1, data_ready=0, done=0, error=0, and no cfg_enable pulses over 100 cycles.
- CONFIG_WIDTH=10, start, send A5, 8'h5A, 8'h03, checksum 8'h59 -> cfg_nreset low 2 cycles, then cfg_data sequence 0,1,0,1,1,0,1,0,1,1 over 10 enable cycles -> done=1, error=0.
- Same as above with checksum 8'h00 -> exactly 10 enable cycles, then error=1, cfg_nreset=0, done=0.
- Header 8'h3C -> error=1 with zero enable cycles, and no further bytes accepted until start.
- Default width, 255 random bytes with correct XOR, data_valid randomly deasserted 30% of the time -> exactly 2034 enable cycles; a scoreboard of the chain model matches expected bits; done=1.
- nreset asserted during the 100th SHIFT cycle -> all outputs at reset values immediately; next start performs a full clean load.
